spell_stack_unit: RTL and testbench

SPELL_STACK_UNIT -- requirements
Module: spell_stack_unit

---
 rtl/spell_stack_unit.sv | 157 +++++++++++++++
 tb/tb_spell_stack_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spell_stack_unit.sv
// rtl/spell_stack_unit.sv - multi-entry push/pop stack with error flags and debug port
//
// Purpose: a register-based LIFO that can pop 0..2 and then push 0..2 entries in
// a single cycle. Checked mode (WRAP=0) rejects underflow/overflow and records them
// in sticky flags. Legacy mode (WRAP=1) lets the pointer wrap modulo DEPTH. A
// low-priority debug port reads or writes any entry by absolute index.
//
// Ports:
//   clock, reset       - rising-edge clock, asynchronous active-low reset
//   op_valid           - apply op_pop/op_push this cycle
//   op_pop, op_push    - entries removed, then entries added (0..2; 3 is illegal)
//   op_data0, op_data1 - new top, new below-top (the latter only for op_push=2)
//   err_clr            - clears err_ovf/err_unf (a same-cycle set wins)
//   dbg_stb/we/idx/wdata - debug request, served only when op_valid=0
//   dbg_ack, dbg_rdata - one-cycle completion pulse, registered read data
//   top, below         - entry[count-1] and entry[count-2], zero when absent
//   count, empty, full - current depth and its decodes
//   err_ovf, err_unf   - sticky overflow/underflow flags
//   op_err             - one-cycle pulse for a rejected operation
module spell_stack_unit #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter bit WRAP   = 1'b0,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [1:0]        op_pop,
  input  logic [1:0]        op_push,
  input  logic [DATA_W-1:0] op_data0,
  input  logic [DATA_W-1:0] op_data1,
  input  logic              err_clr,
  input  logic              dbg_stb,
  input  logic              dbg_we,
  input  logic [CW-1:0]     dbg_idx,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [DATA_W-1:0] top,
  output logic [DATA_W-1:0] below,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic              err_ovf,
  output logic              err_unf,
  output logic              op_err
);

  localparam int AW = CW - 1;
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     count_q;
  logic              err_ovf_q;
  logic              err_unf_q;
  logic              op_err_q;
  logic              dbg_ack_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic              illegal;
  logic              unf;
  logic              ovf;
  logic              accept;
  logic [CW:0]       sum_x;
  logic [CW-1:0]     count_n;
  logic [AW-1:0]     wa0;
  logic [AW-1:0]     wa1;
  logic              dbg_serve;
  logic              dbg_in_range;
  logic [DATA_W-1:0] dbg_rd_val;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     below_idx;
  logic              err_ovf_n;
  logic              err_unf_n;

  always_comb begin
    illegal      = (op_pop == 2'd3) || (op_push == 2'd3);
    // One extra bit so that count - pop + push never aliases before comparison.
    sum_x        = {1'b0, count_q} + {{(CW-1){1'b0}}, op_push}
                                   - {{(CW-1){1'b0}}, op_pop};
    unf          = !WRAP && ({{(CW-2){1'b0}}, op_pop} > count_q);
    // Underflow takes priority, so overflow is only judged when no underflow.
    ovf          = !WRAP && !unf && (sum_x > DEPTH_X);
    accept       = op_valid && !illegal && !unf && !ovf;
    count_n      = WRAP ? {1'b0, sum_x[AW-1:0]} : sum_x[CW-1:0];
    // Low AW bits give the modulo-DEPTH slot in both modes.
    wa0          = sum_x[AW-1:0] - AW'(1);
    wa1          = sum_x[AW-1:0] - AW'(2);
    // Operations own the storage; a request still strobing in its ack cycle is
    // the same request and must not be served twice.
    dbg_serve    = dbg_stb && !op_valid && !dbg_ack_q;
    dbg_in_range = dbg_idx < DEPTH_C;
    dbg_rd_val   = dbg_in_range ? mem[dbg_idx[AW-1:0]] : '0;
    top_idx      = count_q[AW-1:0] - AW'(1);
    below_idx    = count_q[AW-1:0] - AW'(2);
    // A flag being set in the same cycle beats err_clr.
    err_unf_n    = (op_valid && !illegal && unf) ? 1'b1 :
                   (err_clr ? 1'b0 : err_unf_q);
    err_ovf_n    = (op_valid && !illegal && ovf) ? 1'b1 :
                   (err_clr ? 1'b0 : err_ovf_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (accept) begin
      if (op_push != 2'd0) begin
        mem[wa0] <= op_data0;
      end
      if (op_push == 2'd2) begin
        mem[wa1] <= op_data1;
      end
    end else if (dbg_serve && dbg_we && dbg_in_range) begin
      mem[dbg_idx[AW-1:0]] <= dbg_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
      op_err_q    <= 1'b0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      if (accept) begin
        count_q <= count_n;
      end
      err_ovf_q <= err_ovf_n;
      err_unf_q <= err_unf_n;
      op_err_q  <= op_valid && !accept;
      dbg_ack_q <= dbg_serve;
      if (dbg_serve && !dbg_we) begin
        dbg_rdata_q <= dbg_rd_val;
      end
    end
  end

  always_comb begin
    count     = count_q;
    empty     = (count_q == '0);
    full      = !WRAP && (count_q == DEPTH_C);
    top       = (count_q == '0) ? '0 : mem[top_idx];
    below     = (count_q < CW'(2)) ? '0 : mem[below_idx];
    err_ovf   = err_ovf_q;
    err_unf   = err_unf_q;
    op_err    = op_err_q;
    dbg_ack   = dbg_ack_q;
    dbg_rdata = dbg_rdata_q;
  end

endmodule

// File: tb/tb_spell_stack_unit.sv
// tb/tb_spell_stack_unit.sv - checks spell_stack_unit in checked and wrap modes against a reference model
module tb_spell_stack_unit;

  localparam int DEP = 32;
  localparam int CW  = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic       op_valid;
  logic [1:0] op_pop, op_push;
  logic [7:0] op_data0, op_data1;
  logic       err_clr, dbg_stb, dbg_we;
  logic [CW-1:0] dbg_idx;
  logic [7:0] dbg_wdata;

  logic       dbg_ack_c, empty_c, full_c, err_ovf_c, err_unf_c, op_err_c;
  logic [7:0] dbg_rdata_c, top_c, below_c;
  logic [CW-1:0] count_c;
  logic       dbg_ack_w, empty_w, full_w, err_ovf_w, err_unf_w, op_err_w;
  logic [7:0] dbg_rdata_w, top_w, below_w;
  logic [CW-1:0] count_w;

  always #5 clock = ~clock;

  spell_stack_unit #(.DATA_W(8), .DEPTH(DEP), .WRAP(1'b0)) dut_chk (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_pop(op_pop),
    .op_push(op_push), .op_data0(op_data0), .op_data1(op_data1),
    .err_clr(err_clr), .dbg_stb(dbg_stb), .dbg_we(dbg_we), .dbg_idx(dbg_idx),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack_c), .dbg_rdata(dbg_rdata_c),
    .top(top_c), .below(below_c), .count(count_c), .empty(empty_c),
    .full(full_c), .err_ovf(err_ovf_c), .err_unf(err_unf_c), .op_err(op_err_c)
  );

  spell_stack_unit #(.DATA_W(8), .DEPTH(DEP), .WRAP(1'b1)) dut_wrap (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_pop(op_pop),
    .op_push(op_push), .op_data0(op_data0), .op_data1(op_data1),
    .err_clr(err_clr), .dbg_stb(dbg_stb), .dbg_we(dbg_we), .dbg_idx(dbg_idx),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack_w), .dbg_rdata(dbg_rdata_w),
    .top(top_w), .below(below_w), .count(count_w), .empty(empty_w),
    .full(full_w), .err_ovf(err_ovf_w), .err_unf(err_unf_w), .op_err(op_err_w)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: index 0 = checked instance, 1 = wrap instance.
  int mm [2][DEP];
  int mc [2];
  bit m_ovf [2], m_unf [2], m_err [2], m_ack [2];
  int m_rd [2];

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wrap_idx(input int x);
    return ((x % DEP) + DEP) % DEP;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < DEP; i++) mm[w][i] = 0;
      mc[w] = 0; m_ovf[w] = 0; m_unf[w] = 0; m_err[w] = 0; m_ack[w] = 0; m_rd[w] = 0;
    end
  endtask

  task automatic model_step();
    for (int w = 0; w < 2; w++) begin
      bit served, set_u, set_o;
      int nc;
      served = dbg_stb && !op_valid && !m_ack[w];
      set_u = 0; set_o = 0; m_err[w] = 0;
      if (op_valid) begin
        if (op_pop == 3 || op_push == 3) begin
          m_err[w] = 1;
        end else begin
          nc = mc[w] - int'(op_pop) + int'(op_push);
          if (w == 0 && int'(op_pop) > mc[w]) begin
            m_err[w] = 1; set_u = 1;
          end else if (w == 0 && nc > DEP) begin
            m_err[w] = 1; set_o = 1;
          end else begin
            if (w == 1) nc = wrap_idx(nc);
            mc[w] = nc;
            if (op_push >= 1) mm[w][wrap_idx(nc - 1)] = int'(op_data0);
            if (op_push == 2) mm[w][wrap_idx(nc - 2)] = int'(op_data1);
          end
        end
      end
      if (served) begin
        if (dbg_we) begin
          if (int'(dbg_idx) < DEP) mm[w][dbg_idx] = int'(dbg_wdata);
        end else begin
          m_rd[w] = (int'(dbg_idx) < DEP) ? mm[w][dbg_idx] : 0;
        end
      end
      m_ack[w] = served;
      m_unf[w] = set_u ? 1'b1 : (err_clr ? 1'b0 : m_unf[w]);
      m_ovf[w] = set_o ? 1'b1 : (err_clr ? 1'b0 : m_ovf[w]);
    end
  endtask

  task automatic check_one(input int w, input logic [CW-1:0] cnt, input logic [7:0] tp,
                           input logic [7:0] bl, input logic emp, input logic ful,
                           input logic ov, input logic un, input logic oe,
                           input logic ack, input logic [7:0] rd);
    int c;
    c = mc[w];
    expect_eq($sformatf("w%0d count", w), 32'(cnt), 32'(c));
    expect_eq($sformatf("w%0d top", w), 32'(tp), (c == 0) ? 0 : 32'(mm[w][wrap_idx(c - 1)]));
    expect_eq($sformatf("w%0d below", w), 32'(bl), (c < 2) ? 0 : 32'(mm[w][wrap_idx(c - 2)]));
    expect_eq($sformatf("w%0d empty", w), 32'(emp), 32'(c == 0));
    expect_eq($sformatf("w%0d full", w), 32'(ful), 32'(c == DEP));
    expect_eq($sformatf("w%0d err_ovf", w), 32'(ov), 32'(m_ovf[w]));
    expect_eq($sformatf("w%0d err_unf", w), 32'(un), 32'(m_unf[w]));
    expect_eq($sformatf("w%0d op_err", w), 32'(oe), 32'(m_err[w]));
    expect_eq($sformatf("w%0d dbg_ack", w), 32'(ack), 32'(m_ack[w]));
    expect_eq($sformatf("w%0d dbg_rdata", w), 32'(rd), 32'(m_rd[w]));
  endtask

  task automatic check_all();
    check_one(0, count_c, top_c, below_c, empty_c, full_c, err_ovf_c, err_unf_c,
              op_err_c, dbg_ack_c, dbg_rdata_c);
    check_one(1, count_w, top_w, below_w, empty_w, full_w, err_ovf_w, err_unf_w,
              op_err_w, dbg_ack_w, dbg_rdata_w);
  endtask

  task automatic clear_inputs();
    op_valid = 0; op_pop = 0; op_push = 0; op_data0 = 0; op_data1 = 0;
    err_clr = 0; dbg_stb = 0; dbg_we = 0; dbg_idx = 0; dbg_wdata = 0;
  endtask

  task automatic step(input logic v, input logic [1:0] pop, input logic [1:0] push,
                      input logic [7:0] d0, input logic [7:0] d1, input logic clr,
                      input logic stb, input logic we, input logic [CW-1:0] idx,
                      input logic [7:0] wd);
    op_valid = v; op_pop = pop; op_push = push; op_data0 = d0; op_data1 = d1;
    err_clr = clr; dbg_stb = stb; dbg_we = we; dbg_idx = idx; dbg_wdata = wd;
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic op(input logic [1:0] pop, input logic [1:0] push,
                    input logic [7:0] d0, input logic [7:0] d1);
    step(1'b1, pop, push, d0, d1, 1'b0, 1'b0, 1'b0, '0, 8'h00);
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, '0, 8'h00);
  endtask

  // Reset lands between clock edges, so the outputs must clear without a clock.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    check_all();
    @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    #2;
    reset = 1'b0;
    #1;
    check_all();
    expect_eq("reset empty", 32'(empty_c), 1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Push/pop basics
    op(2'd0, 2'd1, 8'h11, 8'h00);
    op(2'd0, 2'd2, 8'h22, 8'h33);
    expect_eq("push2 count", 32'(count_c), 3);
    expect_eq("push2 top", 32'(top_c), 32'h22);
    expect_eq("push2 below", 32'(below_c), 32'h33);
    op(2'd2, 2'd0, 8'h00, 8'h00);
    expect_eq("pop2 count", 32'(count_c), 1);
    expect_eq("pop2 top", 32'(top_c), 32'h11);

    // Debug contention: held off by op_valid, served once after it drops
    step(1'b1, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, '0, 8'h00);
    expect_eq("contend ack1", 32'(dbg_ack_c), 0);
    step(1'b1, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, '0, 8'h00);
    expect_eq("contend ack2", 32'(dbg_ack_c), 0);
    step(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, '0, 8'h00);
    expect_eq("served ack", 32'(dbg_ack_c), 1);
    expect_eq("served rdata", 32'(dbg_rdata_c), 32'h11);
    step(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, '0, 8'h00);
    expect_eq("no double ack", 32'(dbg_ack_c), 0);
    idle();

    // Debug write, read back, out-of-range read
    step(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 6'd5, 8'hA5);
    idle();
    step(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 6'd5, 8'h00);
    expect_eq("dbg wr/rd", 32'(dbg_rdata_c), 32'hA5);
    expect_eq("dbg wr count", 32'(count_c), 1);
    idle();
    step(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 6'd40, 8'h00);
    expect_eq("dbg oor rdata", 32'(dbg_rdata_c), 0);
    idle();

    // Replace: pop 2 / push 1 at count 2
    op(2'd0, 2'd1, 8'h44, 8'h00);
    op(2'd2, 2'd1, 8'h5A, 8'h00);
    expect_eq("replace count", 32'(count_c), 1);
    expect_eq("replace top", 32'(top_c), 32'h5A);
    expect_eq("replace op_err", 32'(op_err_c), 0);

    // Underflow, pulse length, clear, clear-vs-set priority, illegal op, NOP
    op(2'd2, 2'd0, 8'h00, 8'h00);
    expect_eq("unf op_err", 32'(op_err_c), 1);
    expect_eq("unf flag", 32'(err_unf_c), 1);
    expect_eq("unf count", 32'(count_c), 1);
    idle();
    expect_eq("unf pulse end", 32'(op_err_c), 0);
    step(1'b0, 2'd0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, '0, 8'h00);
    expect_eq("unf cleared", 32'(err_unf_c), 0);
    step(1'b1, 2'd2, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, '0, 8'h00);
    expect_eq("set beats clr", 32'(err_unf_c), 1);
    op(2'd3, 2'd0, 8'h00, 8'h00);
    expect_eq("illegal op_err", 32'(op_err_c), 1);
    op(2'd0, 2'd3, 8'h00, 8'h00);
    op(2'd0, 2'd0, 8'h00, 8'h00);
    expect_eq("nop op_err", 32'(op_err_c), 0);

    // Fill to full, then overflow, then pop1/push1 at full
    do_reset();
    for (int i = 0; i < 16; i++) op(2'd0, 2'd2, 8'(i), 8'(i + 100));
    expect_eq("fill full", 32'(full_c), 1);
    expect_eq("fill count", 32'(count_c), 32);
    op(2'd0, 2'd1, 8'hEE, 8'h00);
    expect_eq("ovf flag", 32'(err_ovf_c), 1);
    expect_eq("ovf count", 32'(count_c), 32);
    expect_eq("ovf top", 32'(top_c), 15);
    op(2'd1, 2'd1, 8'h77, 8'h00);
    expect_eq("full replace err", 32'(op_err_c), 0);
    expect_eq("full replace top", 32'(top_c), 32'h77);

    // Wrap mode underflow from empty
    do_reset();
    op(2'd1, 2'd0, 8'h00, 8'h00);
    expect_eq("wrap count", 32'(count_w), 31);
    expect_eq("wrap unf", 32'(err_unf_w), 0);
    expect_eq("wrap ovf", 32'(err_ovf_w), 0);
    expect_eq("chk unf", 32'(err_unf_c), 1);

    // Reset in the middle of a held-off debug request
    step(1'b1, 2'd0, 2'd1, 8'h99, 8'h00, 1'b0, 1'b1, 1'b0, '0, 8'h00);
    do_reset();
    idle();
    expect_eq("post-reset ack", 32'(dbg_ack_c), 0);
    idle();

    // Randomized traffic, alternating push-heavy and pop-heavy phases
    for (int i = 0; i < 600; i++) begin
      logic [1:0] p, q;
      if (((i / 50) % 2) == 0) begin
        p = 2'($urandom_range(0, 1));
        q = 2'($urandom_range(1, 2));
      end else begin
        p = 2'($urandom_range(1, 2));
        q = 2'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 19) == 0) p = 2'd3;
      if ($urandom_range(0, 19) == 0) q = 2'd3;
      step(1'($urandom_range(0, 3) != 0), p, q, 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 39)), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
